// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the sprite draw-list scheduler.
package sprite_sched_pkg;

  localparam int unsigned SCHED_CORDW   = 10;
  localparam int unsigned SCHED_SPR_IDW = 4;

  localparam logic [1:0] STATUS_OVERRUN = 2'd0;
  localparam logic [1:0] STATUS_CLIP    = 2'd1;
  localparam logic [1:0] STATUS_WDOG    = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    CLEAR,
    DRAW,
    DRAIN,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic                     valid;
    logic [SCHED_CORDW-1:0]   x;
    logic [SCHED_CORDW-1:0]   y;
    logic [2:0]               scale;
    logic [SCHED_SPR_IDW-1:0] id;
  } sprite_desc_t;

endpackage

// File: rtl/sprite_desc_table.sv
// Sprite descriptor storage: one write port, one synchronous read-first read port.
module sprite_desc_table
  import sprite_sched_pkg::*;
#(
  parameter int unsigned  DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  sprite_desc_t wdata,
  input  logic [AW-1:0] raddr,
  output sprite_desc_t rdata
);

  sprite_desc_t mem [DEPTH];

  // Read-first: a write to the address being read returns the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '{default: '0};
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
      if (we) mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame draw-list walker sequencing the sprite renderer.
// Optional pass watchdog enabled by defining SPRITE_SCHED_WDOG_EN.
module sprite_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int unsigned  CORDW       = 10,
  parameter int unsigned  MAX_SPRITES = 16,
  parameter int unsigned  SPR_IDW     = 4,
  parameter int unsigned  SPR_WIDTH   = 32,
  parameter int unsigned  SPR_HEIGHT  = 32,
  parameter int unsigned  H_RES       = 800,
  parameter int unsigned  V_RES       = 480,
  parameter int unsigned  WDOG_CYCLES = 65536,
  localparam int unsigned AW          = $clog2(MAX_SPRITES),
  localparam int unsigned CW          = $clog2(MAX_SPRITES) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [CORDW-1:0]   cfg_x,
  input  logic [CORDW-1:0]   cfg_y,
  input  logic [2:0]         cfg_scale,
  input  logic [SPR_IDW-1:0] cfg_id,
  input  logic               cfg_valid,
  output logic               ren_rst,
  output logic               ren_enable,
  output logic [CORDW-1:0]   ren_sx,
  output logic [CORDW-1:0]   ren_sy,
  output logic [2:0]         ren_scale,
  output logic [SPR_IDW-1:0] ren_sel,
  input  logic               ren_finished,
  output logic               busy,
  output logic               frame_done,
  output logic [CW-1:0]      drawn_cnt,
  output logic [2:0]         status
);

  localparam int unsigned BW = CORDW + 4;

  if (CORDW != SCHED_CORDW || SPR_IDW != SCHED_SPR_IDW || WDOG_CYCLES < 2 ||
      (MAX_SPRITES & (MAX_SPRITES - 1)) != 0) begin : g_bad_cfg
    $error("sprite_scheduler: unsupported parameter set");
  end

  sched_state_t  state;
  logic [AW-1:0] idx;
  sprite_desc_t  wr_desc;
  sprite_desc_t  rd_desc;
  logic [BW-1:0] x_end_c;
  logic [BW-1:0] y_end_c;
  logic          in_bounds_c;
  logic          last_c;
  logic          wdog_hit_c;

  assign wr_desc = '{valid: cfg_valid, x: cfg_x, y: cfg_y, scale: cfg_scale, id: cfg_id};

  sprite_desc_table #(.DEPTH(MAX_SPRITES)) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (wr_desc),
    .raddr (idx),
    .rdata (rd_desc)
  );

  // Far edge of the scaled sprite; widened so the largest scale cannot wrap.
  assign x_end_c     = BW'(rd_desc.x) + BW'(SPR_WIDTH) * (BW'(rd_desc.scale) + BW'(1));
  assign y_end_c     = BW'(rd_desc.y) + BW'(SPR_HEIGHT) * (BW'(rd_desc.scale) + BW'(1));
  assign in_bounds_c = (x_end_c <= BW'(H_RES)) && (y_end_c <= BW'(V_RES));
  assign last_c      = (idx == AW'(MAX_SPRITES - 1));

`ifdef SPRITE_SCHED_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES) + 1;
  logic [WW-1:0] wdog_cnt;

  // Counts cycles spent in DRAW for the current pass.
  always_ff @(posedge clk) begin
    if (rst || state != DRAW) wdog_cnt <= '0;
    else                      wdog_cnt <= wdog_cnt + WW'(1);
  end

  assign wdog_hit_c = (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
  assign wdog_hit_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      ren_rst    <= 1'b0;
      ren_enable <= 1'b0;
      ren_sx     <= '0;
      ren_sy     <= '0;
      ren_scale  <= '0;
      ren_sel    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drawn_cnt  <= '0;
      status     <= '0;
    end else begin
      ren_rst    <= 1'b0;
      frame_done <= 1'b0;
      if (frame_start && state != IDLE) status[STATUS_OVERRUN] <= 1'b1;

      case (state)
        IDLE: begin
          if (frame_start) begin
            idx       <= '0;
            drawn_cnt <= '0;
            busy      <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          ren_sx    <= rd_desc.x;
          ren_sy    <= rd_desc.y;
          ren_scale <= rd_desc.scale;
          ren_sel   <= rd_desc.id;
          if (rd_desc.valid && in_bounds_c) begin
            ren_rst <= 1'b1;
            state   <= CLEAR;
          end else begin
            if (rd_desc.valid) status[STATUS_CLIP] <= 1'b1;
            if (last_c) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx   <= idx + AW'(1);
              state <= FETCH;
            end
          end
        end
        CLEAR: begin
          ren_enable <= 1'b1;
          state      <= DRAW;
        end
        DRAW: begin
          if (ren_finished) begin
            ren_enable <= 1'b0;
            drawn_cnt  <= drawn_cnt + CW'(1);
            state      <= DRAIN;
          end else if (wdog_hit_c) begin
            ren_enable          <= 1'b0;
            status[STATUS_WDOG] <= 1'b1;
            state               <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_c) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            idx   <= idx + AW'(1);
            state <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler with a table-level reference model.
module tb_sprite_scheduler;

  localparam int NSPR = 16;
  localparam int WDOG = 100;

  logic       clk = 1'b0;
  logic       rst, frame_start, cfg_we, cfg_valid;
  logic [3:0] cfg_addr, cfg_id;
  logic [9:0] cfg_x, cfg_y;
  logic [2:0] cfg_scale;
  logic       ren_rst, ren_enable, ren_finished;
  logic [9:0] ren_sx, ren_sy;
  logic [2:0] ren_scale;
  logic [3:0] ren_sel;
  logic       busy, frame_done;
  logic [4:0] drawn_cnt;
  logic [2:0] status;

  sprite_scheduler #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_scale(cfg_scale),
    .cfg_id(cfg_id), .cfg_valid(cfg_valid), .ren_rst(ren_rst),
    .ren_enable(ren_enable), .ren_sx(ren_sx), .ren_sy(ren_sy),
    .ren_scale(ren_scale), .ren_sel(ren_sel), .ren_finished(ren_finished),
    .busy(busy), .frame_done(frame_done), .drawn_cnt(drawn_cnt), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct { bit valid; int x; int y; int scale; int id; } mdesc_t;
  typedef struct { int x; int y; int scale; int id; } draw_t;

  mdesc_t tbl [NSPR];
  draw_t  exp_draw [$];
  int     exp_cnt [$];
  bit     m_over, m_clip, m_wdog;
  int     n_cmp = 0, n_err = 0;
  int     cyc = 0, fs_cyc = 0, first_rst_cyc = -1;
  int     lat = 4, rcnt = 0;
  bit     hang = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Renderer stand-in: finishes lat enabled cycles after each clear, level held.
  initial begin
    ren_finished = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst || ren_rst) begin
        ren_finished = 1'b0;
        rcnt = 0;
      end else if (ren_enable && !hang) begin
        rcnt++;
        if (rcnt >= lat) ren_finished = 1'b1;
      end
    end
  end

  // Monitor: every clear pulse and every frame end is checked against the queues.
  initial begin
    draw_t d;
    int    c;
    forever begin
      @(negedge clk);
      if (!rst && ren_rst) begin
        if (first_rst_cyc < 0) first_rst_cyc = cyc;
        if (exp_draw.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_ren_rst: got pulse at cycle %0d, want none", cyc);
        end else begin
          d = exp_draw.pop_front();
          check("ren_sx", int'(ren_sx), d.x);
          check("ren_sy", int'(ren_sy), d.y);
          check("ren_scale", int'(ren_scale), d.scale);
          check("ren_sel", int'(ren_sel), d.id);
        end
      end
      if (!rst && frame_done) begin
        if (exp_cnt.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_frame_done: got pulse at cycle %0d, want none", cyc);
        end else begin
          c = exp_cnt.pop_front();
          check("drawn_cnt", int'(drawn_cnt), c);
          check("status", int'(status), int'({m_wdog, m_clip, m_over}));
        end
      end
    end
  end

  task automatic cfg_write(input int a, input int v, input int x, input int y,
                           input int s, input int id);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_valid = (v != 0);
    cfg_x = 10'(x); cfg_y = 10'(y); cfg_scale = 3'(s); cfg_id = 4'(id);
    @(negedge clk);
    cfg_we = 1'b0;
    tbl[a] = '{valid: (v != 0), x: x, y: y, scale: s, id: id};
  endtask

  task automatic clear_table();
    for (int i = 0; i < NSPR; i++) cfg_write(i, 0, 0, 0, 0, 0);
  endtask

  // Model: in index order, draw every valid entry that fits the screen.
  task automatic start_frame(input int hung_passes);
    int nd = 0;
    for (int i = 0; i < NSPR; i++) begin
      if (tbl[i].valid) begin
        if (tbl[i].x + 32 * (tbl[i].scale + 1) <= 800 &&
            tbl[i].y + 32 * (tbl[i].scale + 1) <= 480) begin
          exp_draw.push_back('{x: tbl[i].x, y: tbl[i].y, scale: tbl[i].scale, id: tbl[i].id});
          nd++;
        end else begin
          m_clip = 1'b1;
        end
      end
    end
    if (hung_passes > 0) m_wdog = 1'b1;
    exp_cnt.push_back(nd - hung_passes);
    first_rst_cyc = -1;
    @(negedge clk);
    frame_start = 1'b1;
    fs_cyc = cyc;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (frame_done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (dcyc < 0) begin
      n_cmp++; n_err++;
      $display("FAIL frame_done_timeout: got none within %0d cycles, want pulse", budget);
    end
  endtask

  task automatic wait_enable(input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      @(negedge clk);
      if (ren_enable) seen = 1;
    end
    check("ren_enable_seen", seen, 1);
  endtask

  initial begin
    int dc;
    rst = 1'b1; frame_start = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_valid = 1'b0;
    cfg_x = '0; cfg_y = '0; cfg_scale = '0; cfg_id = '0;
    m_over = 1'b0; m_clip = 1'b0; m_wdog = 1'b0;
    for (int i = 0; i < NSPR; i++) tbl[i] = '{valid: 1'b0, x: 0, y: 0, scale: 0, id: 0};
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_ren_enable", int'(ren_enable), 0);
    check("rst_ren_rst", int'(ren_rst), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_drawn_cnt", int'(drawn_cnt), 0);
    check("rst_status", int'(status), 0);
    check("rst_ren_sx", int'(ren_sx), 0);
    rst = 1'b0;

    // Entries 0 and 3 valid, long render time.
    lat = 1024;
    cfg_write(0, 1, 100, 50, 0, 1);
    cfg_write(3, 1, 100, 50, 0, 2);
    start_frame(0);
    wait_done(5000, dc);
    check("first_ren_rst_latency", first_rst_cyc - fs_cyc, 3);
    check("draws_left_a", exp_draw.size(), 0);

    // Entry 0 just past the right edge: clipped.
    lat = 3;
    clear_table();
    cfg_write(0, 1, 780, 50, 0, 4);
    start_frame(0);
    wait_done(500, dc);
    check("clip_frame_len", dc - fs_cyc, 1 + 2 * NSPR);
    check("clip_no_ren_rst", first_rst_cyc, -1);

    // Exact bottom-right fit is drawn.
    cfg_write(0, 1, 768, 448, 0, 5);
    start_frame(0);
    wait_done(500, dc);
    check("draws_left_edge", exp_draw.size(), 0);

    // Re-pulse while busy is ignored but flagged.
    lat = 30;
    for (int i = 0; i < 4; i++) cfg_write(i, 1, 10 * i, 20 * i, i % 3, i);
    start_frame(0);
    repeat (10) @(negedge clk);
    frame_start = 1'b1;
    m_over = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_done(2000, dc);
    check("busy_in_done", int'(busy), 1);
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    check("draws_left_over", exp_draw.size(), 0);

    // Empty table timing.
    clear_table();
    start_frame(0);
    wait_done(500, dc);
    check("empty_frame_len", dc - fs_cyc, 1 + 2 * NSPR);

    // Randomized tables and render latencies.
    for (int f = 0; f < 12; f++) begin
      lat = int'($urandom_range(1, 12));
      for (int i = 0; i < NSPR; i++)
        cfg_write(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 800)),
                  int'($urandom_range(0, 480)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)));
      start_frame(0);
      wait_done(5000, dc);
      check("draws_left_rand", exp_draw.size(), 0);
    end

`ifdef SPRITE_SCHED_WDOG_EN
    // Hung renderer on entry 0, entry 1 renders normally.
    begin
      int en_cycles = 0;
      clear_table();
      lat = 5;
      hang = 1'b1;
      cfg_write(0, 1, 0, 0, 0, 1);
      cfg_write(1, 1, 64, 64, 1, 2);
      start_frame(1);
      wait_enable(20);
      en_cycles = 1;
      for (int i = 0; i < 1000 && ren_enable; i++) begin
        @(negedge clk);
        if (ren_enable) en_cycles++;
      end
      check("wdog_enable_cycles", en_cycles, WDOG);
      hang = 1'b0;
      wait_done(500, dc);
      check("wdog_status_bit", int'(status[2]), 1);
    end
`endif

    // Reset in the middle of a pass.
    lat = 1000;
    cfg_write(0, 1, 40, 40, 0, 3);
    start_frame(0);
    wait_enable(20);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ren_enable", int'(ren_enable), 0);
    check("midrst_status", int'(status), 0);
    check("midrst_drawn_cnt", int'(drawn_cnt), 0);
    rst = 1'b0;
    exp_draw.delete();
    exp_cnt.delete();
    m_over = 1'b0; m_clip = 1'b0; m_wdog = 1'b0;
    for (int i = 0; i < NSPR; i++) tbl[i] = '{valid: 1'b0, x: 0, y: 0, scale: 0, id: 0};
    start_frame(0);
    wait_done(500, dc);
    check("post_rst_frame_len", dc - fs_cyc, 1 + 2 * NSPR);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
